// File: rtl/irda_mir_tx_framer.sv
// MIR transmit framer: STA flags, zero-bit-stuffed payload, STO flags.
// Define IRDA_MIR_TX_CRC_EN to append a stuffed, complemented CRC-16 FCS.
module irda_mir_tx_framer #(
  parameter int STA_FLAGS = 2,
  parameter int STO_FLAGS = 1
) (
  input  logic       clk,
  input  logic       wb_rst_n,
  input  logic       mir_txbit_enable,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       tx_data_valid,
  input  logic       tx_last,
  output logic       tx_data_ack,
  output logic       tx_o,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_underrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STA,
    S_DATA,
    S_STUFF,
    S_STO,
    S_ABORT
`ifdef IRDA_MIR_TX_CRC_EN
    , S_FCS
`endif
  } state_e;

  localparam logic [7:0] FLAG  = 8'h7E;
  localparam logic [3:0] STA_N = 4'(STA_FLAGS);
  localparam logic [3:0] STO_N = 4'(STO_FLAGS);

`ifdef IRDA_MIR_TX_CRC_EN
  localparam state_e      S_POST = S_FCS;
  localparam logic [15:0] POLY   = 16'h8408;
`else
  localparam state_e      S_POST = S_STO;
`endif

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] flag_cnt_q, flag_cnt_d;
  logic [2:0] ones_q, ones_d, ones_inc;
  logic [7:0] sh_q, sh_d;
  logic       last_q, last_d;
  logic       tx_o_q, tx_o_d;
  logic       ack_q, ack_d;
  logic       done_q, done_d;
  logic       und_q, und_d;
`ifdef IRDA_MIR_TX_CRC_EN
  logic [15:0] crc_q, crc_d;
  logic [4:0]  fcs_cnt_q, fcs_cnt_d;
  logic        crc_fb;
`endif

  always_ff @(posedge clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      flag_cnt_q <= '0;
      ones_q     <= '0;
      sh_q       <= '0;
      last_q     <= 1'b0;
      tx_o_q     <= 1'b0;
      ack_q      <= 1'b0;
      done_q     <= 1'b0;
      und_q      <= 1'b0;
`ifdef IRDA_MIR_TX_CRC_EN
      crc_q      <= '1;
      fcs_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      flag_cnt_q <= flag_cnt_d;
      ones_q     <= ones_d;
      sh_q       <= sh_d;
      last_q     <= last_d;
      tx_o_q     <= tx_o_d;
      ack_q      <= ack_d;
      done_q     <= done_d;
      und_q      <= und_d;
`ifdef IRDA_MIR_TX_CRC_EN
      crc_q      <= crc_d;
      fcs_cnt_q  <= fcs_cnt_d;
`endif
    end
  end

  // Bit emitted on this enabled edge plus the one-clk pulses.
  always_comb begin
    tx_o_d = tx_o_q;
    ack_d  = 1'b0;
    done_d = 1'b0;
    und_d  = 1'b0;
    if (mir_txbit_enable) begin
      unique case (state_q)
        S_IDLE:  tx_o_d = 1'b0;
        S_STA:   tx_o_d = FLAG[bit_cnt_q];
        S_DATA: begin
          if (bit_cnt_q != 3'd0) begin
            tx_o_d = sh_q[0];
          end else if (tx_data_valid) begin
            tx_o_d = tx_data[0];
            ack_d  = 1'b1;
          end else begin
            tx_o_d = 1'b1;
            und_d  = 1'b1;
          end
        end
        S_STUFF: tx_o_d = 1'b0;
        S_STO: begin
          if (flag_cnt_q == STO_N) begin
            tx_o_d = 1'b0;
            done_d = 1'b1;
          end else begin
            tx_o_d = FLAG[bit_cnt_q];
          end
        end
        S_ABORT: tx_o_d = (flag_cnt_q == 4'd0);
`ifdef IRDA_MIR_TX_CRC_EN
        S_FCS:   tx_o_d = ~crc_q[0];
`endif
        default: tx_o_d = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    flag_cnt_d = flag_cnt_q;
    ones_d     = ones_q;
    sh_d       = sh_q;
    last_d     = last_q;
    ones_inc   = tx_o_d ? 3'(ones_q + 3'd1) : 3'd0;
`ifdef IRDA_MIR_TX_CRC_EN
    crc_d      = crc_q;
    fcs_cnt_d  = fcs_cnt_q;
    crc_fb     = crc_q[0] ^ tx_o_d;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (tx_start) begin
          state_d    = S_STA;
          bit_cnt_d  = '0;
          flag_cnt_d = '0;
          ones_d     = '0;
          last_d     = 1'b0;
`ifdef IRDA_MIR_TX_CRC_EN
          crc_d      = '1;
          fcs_cnt_d  = '0;
`endif
        end
      end
      S_STA: begin
        if (mir_txbit_enable) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if ((flag_cnt_q + 4'd1) == STA_N) begin
              state_d    = S_DATA;
              flag_cnt_d = '0;
              ones_d     = '0;
            end else begin
              flag_cnt_d = flag_cnt_q + 4'd1;
            end
          end
        end
      end
      S_DATA: begin
        if (mir_txbit_enable) begin
          if (bit_cnt_q == 3'd0 && !tx_data_valid) begin
            state_d    = S_ABORT;
            bit_cnt_d  = 3'd1;
            flag_cnt_d = '0;
          end else begin
            if (bit_cnt_q == 3'd0) begin
              sh_d   = {1'b0, tx_data[7:1]};
              last_d = tx_last;
            end else begin
              sh_d   = {1'b0, sh_q[7:1]};
            end
            bit_cnt_d = bit_cnt_q + 3'd1;
            ones_d    = ones_inc;
`ifdef IRDA_MIR_TX_CRC_EN
            crc_d = {1'b0, crc_q[15:1]} ^ (crc_fb ? POLY : 16'h0000);
`endif
            if (ones_inc == 3'd5) begin
              state_d = S_STUFF;
            end else if (bit_cnt_q == 3'd7) begin
              state_d = last_q ? S_POST : S_DATA;
            end
          end
        end
      end
      S_STUFF: begin
        if (mir_txbit_enable) begin
          ones_d = '0;
`ifdef IRDA_MIR_TX_CRC_EN
          if (fcs_cnt_q == 5'd16) state_d = S_STO;
          else if (fcs_cnt_q != 5'd0) state_d = S_FCS;
          else if (bit_cnt_q == 3'd0 && last_q) state_d = S_POST;
          else state_d = S_DATA;
`else
          if (bit_cnt_q == 3'd0 && last_q) state_d = S_POST;
          else state_d = S_DATA;
`endif
        end
      end
      S_STO: begin
        if (mir_txbit_enable) begin
          if (flag_cnt_q == STO_N) begin
            state_d    = S_IDLE;
            flag_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) flag_cnt_d = flag_cnt_q + 4'd1;
          end
        end
      end
      S_ABORT: begin
        if (mir_txbit_enable) begin
          if (flag_cnt_q != 4'd0) begin
            state_d    = S_IDLE;
            bit_cnt_d  = '0;
            flag_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) flag_cnt_d = 4'd1;
          end
        end
      end
`ifdef IRDA_MIR_TX_CRC_EN
      S_FCS: begin
        if (mir_txbit_enable) begin
          crc_d     = {1'b0, crc_q[15:1]};
          fcs_cnt_d = fcs_cnt_q + 5'd1;
          ones_d    = ones_inc;
          if (ones_inc == 3'd5) state_d = S_STUFF;
          else if (fcs_cnt_q == 5'd15) state_d = S_STO;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign tx_o        = tx_o_q;
  assign tx_data_ack = ack_q;
  assign tx_done     = done_q;
  assign tx_underrun = und_q;
  assign tx_busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_irda_mir_tx_framer.sv
// Bench for irda_mir_tx_framer: random frames vs a bit-list reference model.
// Scoreboard holds expected {tx_o,ack,underrun,done,busy} per enabled edge.
module tb_irda_mir_tx_framer;
  localparam int STA = 2;
  localparam int STO = 1;
  localparam logic [7:0] FLAG = 8'h7E;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_data_valid = 1'b0;
  logic       tx_last = 1'b0;
  logic       tx_data_ack, tx_o, tx_busy, tx_done, tx_underrun;

  int checks = 0;
  int errors = 0;
  logic [4:0] expq[$];
  logic [7:0] fbytes[$];
  int fidx = 0;
  int fdrop = -1;
  bit in_reset = 1'b1;

  irda_mir_tx_framer #(.STA_FLAGS(STA), .STO_FLAGS(STO)) dut (
    .clk(clk),
    .wb_rst_n(rst_n),
    .mir_txbit_enable(en),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .tx_data_valid(tx_data_valid),
    .tx_last(tx_last),
    .tx_data_ack(tx_data_ack),
    .tx_o(tx_o),
    .tx_busy(tx_busy),
    .tx_done(tx_done),
    .tx_underrun(tx_underrun)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(negedge clk);
    en = ($urandom_range(0, 2) == 0);
  end

  // Byte source: presents fbytes[fidx], advances on each ack.
  initial forever begin
    @(negedge clk);
    if (tx_data_ack) fidx++;
    if (fidx < fbytes.size()) begin
      tx_data       = fbytes[fidx];
      tx_data_valid = (fidx != fdrop);
      tx_last       = (fidx == fbytes.size() - 1);
    end else begin
      tx_data       = 8'($urandom);
      tx_data_valid = 1'b0;
      tx_last       = 1'b0;
    end
  end

  initial begin : mon
    logic e, b;
    logic [4:0] got, exp;
    forever begin
      @(posedge clk);
      e = en;
      b = tx_busy;
      #1;
      if (!in_reset && rst_n) begin
        got = {tx_o, tx_data_ack, tx_underrun, tx_done, tx_busy};
        if (e && b) begin
          checks++;
          if (expq.size() == 0) begin
            errors++;
            $display("FAIL extra_bit got=%b required=none", got);
          end else begin
            exp = expq.pop_front();
            if (got !== exp) begin
              errors++;
              $display("FAIL bit {o,ack,und,done,busy} got=%b required=%b", got, exp);
            end
          end
        end else if (!e) begin
          checks++;
          if ({tx_data_ack, tx_underrun, tx_done} !== 3'b000) begin
            errors++;
            $display("FAIL pulse_hold got=%b required=000",
                     {tx_data_ack, tx_underrun, tx_done});
          end
        end
      end
    end
  end

  task automatic push_bit(input logic v, input int ones_in, output int ones_out);
    expq.push_back({v, 4'b0001});
    ones_out = v ? ones_in + 1 : 0;
    if (ones_out == 5) begin
      expq.push_back(5'b00001);
      ones_out = 0;
    end
  endtask

  task automatic push_frame(input logic [7:0] b[$], input int drop);
    int ones = 0;
    int nb;
    logic [15:0] crc = 16'hFFFF;
    logic v;
    for (int f = 0; f < STA; f++)
      for (int i = 0; i < 8; i++) expq.push_back({FLAG[i], 4'b0001});
    nb = (drop >= 0) ? drop : b.size();
    for (int k = 0; k < nb; k++) begin
      for (int i = 0; i < 8; i++) begin
        v = b[k][i];
        crc = (crc[0] ^ v) ? ((crc >> 1) ^ 16'h8408) : (crc >> 1);
        expq.push_back({v, (i == 0), 3'b001});
        ones = v ? ones + 1 : 0;
        if (ones == 5) begin
          expq.push_back(5'b00001);
          ones = 0;
        end
      end
    end
    if (drop >= 0) begin
      for (int i = 0; i < 8; i++)
        expq.push_back({1'b1, 1'b0, (i == 0), 2'b01});
      expq.push_back(5'b00000);
      return;
    end
`ifdef IRDA_MIR_TX_CRC_EN
    for (int i = 0; i < 16; i++) push_bit(~crc[i], ones, ones);
`endif
    for (int f = 0; f < STO; f++)
      for (int i = 0; i < 8; i++) expq.push_back({FLAG[i], 4'b0001});
    expq.push_back(5'b00010);
  endtask

  task automatic start_frame(input logic [7:0] b[$], input int drop);
    @(posedge clk);
    fbytes = b;
    fidx   = 0;
    fdrop  = drop;
    push_frame(b, drop);
    @(negedge clk);
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] b[$], input int drop, input bit mid);
    int n = 0;
    start_frame(b, drop);
    if (mid) begin
      repeat ($urandom_range(20, 80)) @(negedge clk);
      if (tx_busy) tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
    end
    while (expq.size() != 0 && n < 20000) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL frame_timeout left=%0d required=0", expq.size());
      expq.delete();
    end
    repeat (3) @(posedge clk);
  endtask

  initial begin
    logic [7:0] q[$];
    int n;
    int len;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({tx_o, tx_busy, tx_data_ack, tx_done, tx_underrun} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_state got=%b required=00000",
               {tx_o, tx_busy, tx_data_ack, tx_done, tx_underrun});
    end
    @(negedge clk);
    rst_n = 1'b1;
    in_reset = 1'b0;

    q = {8'h00};               run_frame(q, -1, 1'b0);
    q = {8'hFF};               run_frame(q, -1, 1'b0);
    q = {8'h1F, 8'h01};        run_frame(q, -1, 1'b0);
    q = {8'hF8, 8'h3F};        run_frame(q, -1, 1'b0);
    q = {8'hAA, 8'h55, 8'h12}; run_frame(q, 1, 1'b0);
    q = {8'h01};               run_frame(q, -1, 1'b1);

    // Asynchronous reset in the middle of the payload.
    q = {8'hFF, 8'hFF, 8'hFF, 8'h00};
    start_frame(q, -1);
    n = 0;
    while (fidx < 2 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (fidx < 2) begin
      errors++;
      $display("FAIL reach_data fidx=%0d required=2", fidx);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    in_reset = 1'b1;
    #1;
    checks++;
    if ({tx_o, tx_busy, tx_data_ack, tx_done, tx_underrun} !== 5'b00000) begin
      errors++;
      $display("FAIL async_reset got=%b required=00000",
               {tx_o, tx_busy, tx_data_ack, tx_done, tx_underrun});
    end
    expq.delete();
    fbytes.delete();
    fidx = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    in_reset = 1'b0;
    q = {8'h3C, 8'h7E};        run_frame(q, -1, 1'b0);

    for (int f = 0; f < 25; f++) begin
      len = $urandom_range(1, 5);
      q = {};
      for (int i = 0; i < len; i++)
        q.push_back(($urandom_range(0, 9) < 3) ? 8'hFF : 8'($urandom));
      run_frame(q, ($urandom_range(0, 6) == 0) ? $urandom_range(0, len - 1) : -1,
                1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
